// File: rtl/stack_context_sequencer.sv
// Register-file <-> stack transfer sequencer for one PLC core.
// Runs PUSH/POP (one register) and SAVE/RESTORE (whole context) commands,
// one stack transfer per cycle, aborting on a full or empty stack.
module stack_context_sequencer #(
  parameter int MemorySize = 2,
  parameter int AddrBits   = 4
) (
  input  logic                  CLK,
  input  logic                  CPU_Reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [AddrBits-1:0]   cmd_reg,
  input  logic                  FIFO_EmptySignal,
  input  logic                  FIFO_FullSignal,
  output logic                  FIFO_WR,
  output logic                  FIFO_RD,
  output logic                  FIFO_PUSH_REG,
  output logic                  FIFO_EN,
  output logic                  REGISTERS_WE,
  output logic [AddrBits-1:0]   REGISTERS_ADDR,
  output logic                  done,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic [MemorySize:0]   xfer_count
);

  localparam int RegCount = 2 ** MemorySize;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            op, op_nxt;
  logic [MemorySize-1:0] cur, cur_nxt;
  logic [MemorySize:0]   remain, remain_nxt;
  logic [MemorySize:0]   xfer, xfer_nxt;
  logic                  ovf, ovf_nxt;
  logic                  unf, unf_nxt;
  logic                  push_op;
  logic                  blocked;

  // Only the low MemorySize bits of cmd_reg address a real register.
  logic cmd_reg_unused;
  assign cmd_reg_unused = ^cmd_reg[AddrBits-1:MemorySize];

  assign err_overflow  = ovf;
  assign err_underflow = unf;
  assign xfer_count    = xfer;

  // State and command context registers.
  always_ff @(posedge CLK) begin
    if (CPU_Reset) begin
      state  <= S_IDLE;
      op     <= '0;
      cur    <= '0;
      remain <= '0;
      xfer   <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      op     <= op_nxt;
      cur    <= cur_nxt;
      remain <= remain_nxt;
      xfer   <= xfer_nxt;
      ovf    <= ovf_nxt;
      unf    <= unf_nxt;
    end
  end

  // Next-state and strobe decode; strobes depend only on registered state
  // and the stack full/empty flags.
  always_comb begin
    state_nxt      = state;
    op_nxt         = op;
    cur_nxt        = cur;
    remain_nxt     = remain;
    xfer_nxt       = xfer;
    ovf_nxt        = ovf;
    unf_nxt        = unf;
    cmd_ready      = 1'b0;
    done           = 1'b0;
    FIFO_WR        = 1'b0;
    FIFO_RD        = 1'b0;
    FIFO_PUSH_REG  = 1'b0;
    FIFO_EN        = 1'b0;
    REGISTERS_WE   = 1'b0;
    REGISTERS_ADDR = '0;
    push_op        = ~op[0];
    blocked        = push_op ? FIFO_FullSignal : FIFO_EmptySignal;

    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_nxt    = cmd_op;
          xfer_nxt  = '0;
          ovf_nxt   = 1'b0;
          unf_nxt   = 1'b0;
          state_nxt = S_RUN;
          case (cmd_op)
            2'b10: begin
              cur_nxt    = '0;
              remain_nxt = (MemorySize+1)'(RegCount);
            end
            2'b11: begin
              cur_nxt    = '1;
              remain_nxt = (MemorySize+1)'(RegCount);
            end
            default: begin
              cur_nxt    = cmd_reg[MemorySize-1:0];
              remain_nxt = (MemorySize+1)'(1);
            end
          endcase
        end
      end

      S_RUN: begin
        if (blocked) begin
          if (push_op) ovf_nxt = 1'b1;
          else         unf_nxt = 1'b1;
          state_nxt = S_DONE;
        end else begin
          REGISTERS_ADDR = AddrBits'(cur);
          if (push_op) begin
            FIFO_WR       = 1'b1;
            FIFO_PUSH_REG = 1'b1;
            if (op[1]) cur_nxt = cur + MemorySize'(1);
          end else begin
            FIFO_RD      = 1'b1;
            FIFO_EN      = 1'b1;
            REGISTERS_WE = 1'b1;
            if (op[1]) cur_nxt = cur - MemorySize'(1);
          end
          xfer_nxt   = xfer + (MemorySize+1)'(1);
          remain_nxt = remain - (MemorySize+1)'(1);
          if (remain == (MemorySize+1)'(1)) state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/stack_context_sequencer.md
# stack_context_sequencer

Multi-cycle controller that sequences register-file ↔ stack transfers for one PLC core. It accepts single-register PUSH/POP and whole-context SAVE/RESTORE commands over a valid/ready handshake. For each command it drives the register/stack datapath strobes (`FIFO_WR`, `FIFO_RD`, `FIFO_EN`, `FIFO_PUSH_REG`, `REGISTERS_WE`, `REGISTERS_ADDR`) one transfer per cycle, and reports completion and overflow/underflow. It sits between the core's instruction decoder and the register/stack block.

## Interface
Parameters:
- `MemorySize`, 2, log2 of register count; `RegCount = 2**MemorySize`.
- `AddrBits`, 4, width of the register address port.

Ports:
- `CLK` in 1: single clock, all state on rising edge.
- `CPU_Reset` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 00 PUSH, 01 POP, 10 SAVE, 11 RESTORE.
- `cmd_reg` in AddrBits: register for PUSH/POP; ignored for SAVE/RESTORE.
- `FIFO_EmptySignal` in 1: stack empty, from the stack.
- `FIFO_FullSignal` in 1: stack full, from the stack.
- `FIFO_WR` out 1: stack push strobe.
- `FIFO_RD` out 1: stack pop strobe.
- `FIFO_PUSH_REG` out 1: selects register-file output as stack input.
- `FIFO_EN` out 1: selects stack output as register write data.
- `REGISTERS_WE` out 1: register write enable.
- `REGISTERS_ADDR` out AddrBits: register address; upper bits above MemorySize are always 0.
- `done` out 1: one-cycle completion pulse.
- `err_overflow` out 1: last command aborted on full stack.
- `err_underflow` out 1: last command aborted on empty stack.
- `xfer_count` out MemorySize+1: transfers completed by the last command.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `cmd_ready=1`.
  - On `cmd_valid`, latch op and start address, clear `xfer_count`, `err_overflow` and `err_underflow`, then go to RUN.
  - Start address: PUSH/POP use `cmd_reg`; SAVE uses 0; RESTORE uses RegCount-1.
  - Remaining transfers: 1 for PUSH/POP, RegCount for SAVE/RESTORE.
- RUN, push-type ops (PUSH, SAVE), each cycle:
  - If `FIFO_FullSignal=0`: assert `FIFO_WR=1`, `FIFO_PUSH_REG=1`, `REGISTERS_ADDR=cur`. Increment `xfer_count`. Address increments (SAVE).
  - If `FIFO_FullSignal=1`: no strobe; set `err_overflow`; go to DONE.
- RUN, pop-type ops (POP, RESTORE), each cycle:
  - If `FIFO_EmptySignal=0`: assert `FIFO_RD=1`, `FIFO_EN=1`, `REGISTERS_WE=1`, `REGISTERS_ADDR=cur`. Increment `xfer_count`. Address decrements (RESTORE).
  - If `FIFO_EmptySignal=1`: no strobe; set `err_underflow`; go to DONE.
- RUN exits to DONE after the last transfer cycle.
- DONE: `done=1` for exactly one cycle, then IDLE.
- Error flags and `xfer_count` hold until the next accepted command.
- Ordering: SAVE pushes 0..RegCount-1 and RESTORE pops RegCount-1..0, so SAVE followed by RESTORE restores every register to its saved value.
- Strobes are decoded from registered state, gated combinationally only by the full/empty flags. They never depend on `cmd_valid`.
- Outside RUN, all datapath strobes are 0 and `REGISTERS_ADDR=0`.

## Timing
- Reset: state IDLE. `cmd_ready=1`; all other outputs 0, including `xfer_count`. Reset takes effect at the edge where it is sampled high.
- Reset mid-RUN: strobes drop in the cycle after the reset edge. Partial stack contents are left as-is; the stack's own reset clears it.
- Command accepted at edge E (`cmd_valid & cmd_ready`).
- Transfer k (k=1..n) occurs in cycle E+k. `done` is asserted in cycle E+n+1. `cmd_ready` returns in cycle E+n+2.
- PUSH/POP latency: done 2 cycles after accept. SAVE/RESTORE with RegCount=4: done 5 cycles after accept.
- Abort at transfer k: no strobe in that cycle. `done` is asserted in the next cycle, with `xfer_count=k-1`.
- `cmd_valid` while not ready is ignored and not queued. The requester holds `cmd_valid` until it sees `cmd_ready`.
- Full/empty flags are sampled each RUN cycle. A flag change caused by this block's own strobe is seen the following cycle.

## Test plan
- Reset, then PUSH r2 with R2=0x5A and an empty stack: `FIFO_WR`/`FIFO_PUSH_REG` high for exactly 1 cycle with ADDR=2. `done` follows in the next cycle with `xfer_count=1`, no errors.
- POP r1 with 0x5A on top of the stack: cycle E+1 shows `FIFO_RD`, `FIFO_EN`, `REGISTERS_WE` all high with ADDR=1. R1 reads 0x5A afterwards.
- R0..R3 = 0x11, 0x22, 0x33, 0x44; SAVE; overwrite all registers with 0x00; RESTORE:
  - SAVE ADDR sequence 0,1,2,3; RESTORE ADDR sequence 3,2,1,0.
  - Registers end at 0x11..0x44; each command asserts `done` 5 cycles after accept.
- Stack with 2 free slots, then SAVE: 2 pushes, then `err_overflow=1` and `xfer_count=2`. No `FIFO_WR` in the third RUN cycle.
- Empty stack, then RESTORE: zero strobes, `err_underflow=1` and `done` 2 cycles after accept. Flags clear on the next accepted command.
- `CPU_Reset` asserted in the 2nd RUN cycle of SAVE: strobes 0 from the next cycle, `cmd_ready=1`, no `done` pulse. `cmd_valid` held high during RUN is not accepted until IDLE.
